// File: rtl/dffram_arbiter_if.sv
// Request/response bundle between the core's I-fetch (port 0) and data (port 1)
// requesters and the DFFRAM arbiter.
interface dffram_arbiter_if #(
    parameter int A_WIDTH = 8
);
    logic               p0_req;
    logic [A_WIDTH-1:0] p0_addr;
    logic               p0_gnt;
    logic               p0_rvalid;
    logic [31:0]        p0_rdata;

    logic               p1_req;
    logic [3:0]         p1_we;
    logic [A_WIDTH-1:0] p1_addr;
    logic [31:0]        p1_wdata;
    logic               p1_gnt;
    logic               p1_rvalid;
    logic [31:0]        p1_rdata;

    modport master (
        output p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata
    );

    modport slave (
        input  p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata
    );
endinterface

// File: rtl/dffram_arbiter.sv
// Per-cycle arbiter sharing one single-port DFFRAM between an instruction-fetch
// port (read-only) and a data port (read/write with byte enables).
module dffram_arbiter #(
    parameter int COLS      = 1,
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4,
    localparam int A_WIDTH  = 8 + $clog2(COLS)
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    dffram_arbiter_if.slave    bus,
    output logic               ram_EN,
    output logic [3:0]         ram_WE,
    output logic [A_WIDTH-1:0] ram_A,
    output logic [31:0]        ram_Di,
    input  logic [31:0]        ram_Do,
    output logic [15:0]        conflict_cnt
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic               en;
        logic [3:0]         we;
        logic [A_WIDTH-1:0] a;
        logic [31:0]        di;
    } ram_cmd_t;

    logic              last_grant;   // 0 = port 0 won last, 1 = port 1 won last
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        rvalid_q;
    logic              both;
    logic              starve;
    logic              p0_wins;
    logic              gnt0;
    logic              gnt1;
    ram_cmd_t          cmd;

    always_comb begin
        both    = bus.p0_req & bus.p1_req;
        starve  = (wait_cnt == WAIT_W'(MAX_WAIT));
        p0_wins = (PRIO_MODE == 0) ? last_grant : starve;
        // Grants are gated by reset so the RAM sees no stray enable while held.
        gnt0 = HRESETn & bus.p0_req & (~bus.p1_req | p0_wins);
        gnt1 = HRESETn & bus.p1_req & ~gnt0;
    end

    always_comb begin
        cmd = '0;
        if (gnt0) begin
            cmd.en = 1'b1;
            cmd.a  = bus.p0_addr;
            cmd.di = bus.p1_wdata;
        end else if (gnt1) begin
            cmd.en = 1'b1;
            cmd.we = bus.p1_we;
            cmd.a  = bus.p1_addr;
            cmd.di = bus.p1_wdata;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rvalid_q     <= 2'b00;
            last_grant   <= 1'b1;
            wait_cnt     <= '0;
            conflict_cnt <= 16'd0;
        end else begin
            rvalid_q <= {gnt1 & (bus.p1_we == 4'd0), gnt0};
            if (gnt0)
                last_grant <= 1'b0;
            else if (gnt1)
                last_grant <= 1'b1;
            if (bus.p0_req && !gnt0) begin
                if (!starve)
                    wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (both && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    assign bus.p0_gnt    = gnt0;
    assign bus.p1_gnt    = gnt1;
    assign bus.p0_rvalid = rvalid_q[0];
    assign bus.p1_rvalid = rvalid_q[1];
    // Read data is shared; the rvalid strobes say whose it is.
    assign bus.p0_rdata  = ram_Do;
    assign bus.p1_rdata  = ram_Do;

    assign ram_EN = cmd.en;
    assign ram_WE = cmd.we;
    assign ram_A  = cmd.a;
    assign ram_Di = cmd.di;
endmodule

// File: tb/tb_dffram_arbiter.sv
// Bench for dffram_arbiter: round-robin and fixed-priority instances share one
// directed stimulus stream and are checked each cycle against a behavioural model.
module tb_dffram_arbiter;
    localparam int MAXW = 4;

    logic gclk;
    logic grst_n;

    logic        p0_req;
    logic [7:0]  p0_addr;
    logic        p1_req;
    logic [3:0]  p1_we;
    logic [7:0]  p1_addr;
    logic [31:0] p1_wdata;

    logic [1:0]  gnt0_v, gnt1_v, rv0_v, rv1_v, en_v;
    logic [3:0]  we_a  [2];
    logic [7:0]  a_a   [2];
    logic [31:0] di_a  [2];
    logic [31:0] rd0_a [2];
    logic [31:0] rd1_a [2];
    logic [15:0] cnt_a [2];

    int n_chk = 0;
    int n_err = 0;

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    function automatic logic [31:0] init_word(input int a);
        case (a)
            'h10:    return 32'hDEADBEEF;
            'h05:    return 32'h11223344;
            default: return {8'h5A, 8'(a), 8'(~a), 8'(a ^ 'h3C)};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        dffram_arbiter_if #(.A_WIDTH(8)) pif ();
        logic        ram_en;
        logic [3:0]  ram_we;
        logic [7:0]  ram_a;
        logic [31:0] ram_di;
        logic [31:0] ram_do;
        logic [15:0] cnt;
        logic [31:0] mem [256];

        assign pif.p0_req   = p0_req;
        assign pif.p0_addr  = p0_addr;
        assign pif.p1_req   = p1_req;
        assign pif.p1_we    = p1_we;
        assign pif.p1_addr  = p1_addr;
        assign pif.p1_wdata = p1_wdata;

        dffram_arbiter #(.COLS(1), .PRIO_MODE(g), .MAX_WAIT(MAXW)) dut (
            .HCLK(gclk), .HRESETn(grst_n), .bus(pif),
            .ram_EN(ram_en), .ram_WE(ram_we), .ram_A(ram_a), .ram_Di(ram_di),
            .ram_Do(ram_do), .conflict_cnt(cnt)
        );

        // DFFRAM model: registered read, zero output after a disabled cycle.
        initial for (int k = 0; k < 256; k++) mem[k] = init_word(k);
        always @(posedge gclk) begin
            if (ram_en) begin
                ram_do <= mem[ram_a];
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
            end else begin
                ram_do <= 32'd0;
            end
        end

        assign gnt0_v[g] = pif.p0_gnt;
        assign gnt1_v[g] = pif.p1_gnt;
        assign rv0_v[g]  = pif.p0_rvalid;
        assign rv1_v[g]  = pif.p1_rvalid;
        assign rd0_a[g]  = pif.p0_rdata;
        assign rd1_a[g]  = pif.p1_rdata;
        assign en_v[g]   = ram_en;
        assign we_a[g]   = ram_we;
        assign a_a[g]    = ram_a;
        assign di_a[g]   = ram_di;
        assign cnt_a[g]  = cnt;
    end

    // Behavioural model: memory image, who won last, how long port 0 has waited.
    logic [31:0] mm [2][256];
    logic        m_rv0 [2];
    logic        m_rv1 [2];
    logic [31:0] m_rd  [2];
    int          m_last [2];
    int          m_wait [2];
    int          m_cnt  [2];
    logic        e0, e1, een;
    logic [3:0]  ewe;
    logic [7:0]  ea;
    logic [31:0] edi;

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 256; k++) mm[i][k] = init_word(k);
            m_rv0[i] = 0; m_rv1[i] = 0; m_rd[i] = '0;
            m_last[i] = 1; m_wait[i] = 0; m_cnt[i] = 0;
        end
    end

    always @(negedge gclk) begin
        for (int i = 0; i < 2; i++) begin
            if (!grst_n) begin
                chk($sformatf("i%0d rst gnt", i), {gnt0_v[i], gnt1_v[i]}, 0);
                chk($sformatf("i%0d rst en/we", i), {en_v[i], we_a[i]}, 0);
                chk($sformatf("i%0d rst rvalid", i), {rv0_v[i], rv1_v[i]}, 0);
                chk($sformatf("i%0d rst cnt", i), cnt_a[i], 0);
                m_rv0[i] = 0; m_rv1[i] = 0;
                m_last[i] = 1; m_wait[i] = 0; m_cnt[i] = 0;
            end else begin
                if (p0_req && p1_req) begin
                    e0 = (i == 0) ? (m_last[i] != 0) : (m_wait[i] >= MAXW);
                    e1 = !e0;
                end else begin
                    e0 = p0_req;
                    e1 = p1_req;
                end
                een = e0 | e1;
                ewe = e1 ? p1_we : 4'd0;
                ea  = e0 ? p0_addr : (e1 ? p1_addr : 8'd0);
                edi = een ? p1_wdata : 32'd0;

                chk($sformatf("i%0d gnt", i), {gnt0_v[i], gnt1_v[i]}, {e0, e1});
                chk($sformatf("i%0d ram en/we", i), {en_v[i], we_a[i]}, {een, ewe});
                chk($sformatf("i%0d ram_A", i), a_a[i], ea);
                chk($sformatf("i%0d ram_Di", i), di_a[i], edi);
                chk($sformatf("i%0d rvalid", i), {rv0_v[i], rv1_v[i]}, {m_rv0[i], m_rv1[i]});
                if (m_rv0[i]) chk($sformatf("i%0d p0_rdata", i), rd0_a[i], m_rd[i]);
                if (m_rv1[i]) chk($sformatf("i%0d p1_rdata", i), rd1_a[i], m_rd[i]);
                chk($sformatf("i%0d conflict_cnt", i), cnt_a[i], m_cnt[i]);

                m_rv0[i] = e0;
                m_rv1[i] = e1 && (p1_we == 4'd0);
                if (een) m_rd[i] = mm[i][ea];
                if (e1)
                    for (int b = 0; b < 4; b++)
                        if (p1_we[b]) mm[i][ea][8*b +: 8] = p1_wdata[8*b +: 8];
                if (e0) m_last[i] = 0;
                else if (e1) m_last[i] = 1;
                m_wait[i] = (p0_req && !e0) ? ((m_wait[i] < MAXW) ? m_wait[i] + 1 : MAXW) : 0;
                if (p0_req && p1_req && m_cnt[i] < 'hFFFF) m_cnt[i]++;
            end
        end
    end

    task automatic drive(input logic r0, input logic [7:0] a0, input logic r1,
                         input logic [3:0] we, input logic [7:0] a1, input logic [31:0] wd);
        p0_req = r0; p0_addr = a0; p1_req = r1; p1_we = we; p1_addr = a1; p1_wdata = wd;
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic idle();
        drive(0, 8'h00, 0, 4'h0, 8'h00, 32'h0);
    endtask

    initial begin
        grst_n = 1'b0;
        drive(1, 8'h10, 1, 4'h0, 8'h05, 32'h0);
        @(negedge gclk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("L i%0d reset gnt", i), {gnt0_v[i], gnt1_v[i], en_v[i]}, 0);
            chk($sformatf("L i%0d reset cnt", i), cnt_a[i], 0);
        end
        tick();
        idle();
        grst_n = 1'b1;
        tick();

        // Single port-0 read.
        drive(1, 8'h10, 0, 4'h0, 8'h00, 32'h0);
        @(negedge gclk);
        for (int i = 0; i < 2; i++) chk($sformatf("L i%0d t1 gnt/A", i), {gnt0_v[i], a_a[i]}, {1'b1, 8'h10});
        tick();
        idle();
        @(negedge gclk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("L i%0d t1 rvalid", i), {rv0_v[i], rv1_v[i]}, 2'b10);
            chk($sformatf("L i%0d t1 rdata", i), rd0_a[i], 32'hDEADBEEF);
        end
        tick();

        // Byte write then read back.
        drive(0, 8'h00, 1, 4'b0010, 8'h05, 32'h0000AB00);
        @(negedge gclk);
        for (int i = 0; i < 2; i++) chk($sformatf("L i%0d t2 ram_WE", i), we_a[i], 4'b0010);
        tick();
        drive(0, 8'h00, 1, 4'h0, 8'h05, 32'h0);
        @(negedge gclk);
        for (int i = 0; i < 2; i++) chk($sformatf("L i%0d t2 write rvalid", i), rv1_v[i], 0);
        tick();
        idle();
        @(negedge gclk);
        for (int i = 0; i < 2; i++)
            chk($sformatf("L i%0d t2 read", i), {rv1_v[i], rd1_a[i]}, {1'b1, 32'h1122AB44});
        tick();

        // Port-0 read right after a port-1 write to the same word.
        drive(0, 8'h00, 1, 4'hF, 8'h20, 32'hCAFEF00D);
        tick();
        drive(1, 8'h20, 0, 4'h0, 8'h00, 32'h0);
        tick();
        idle();
        @(negedge gclk);
        for (int i = 0; i < 2; i++)
            chk($sformatf("L i%0d rdw read", i), {rv0_v[i], rd0_a[i]}, {1'b1, 32'hCAFEF00D});
        tick();

        // Two conflict cycles so the reset below has a count to clear.
        drive(1, 8'h10, 1, 4'h0, 8'h05, 32'h0);
        tick();
        tick();
        idle();
        @(negedge gclk);
        for (int i = 0; i < 2; i++) chk($sformatf("L i%0d cnt2", i), cnt_a[i], 2);
        tick();

        // Reset arriving while a read response is due.
        drive(1, 8'h10, 0, 4'h0, 8'h00, 32'h0);
        tick();
        idle();
        for (int i = 0; i < 2; i++) chk($sformatf("L i%0d t5 pre rvalid", i), rv0_v[i], 1);
        grst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) chk($sformatf("L i%0d t5 async drop", i), rv0_v[i], 0);
        @(negedge gclk);
        for (int i = 0; i < 2; i++) chk($sformatf("L i%0d t5 cnt", i), cnt_a[i], 0);
        tick();
        grst_n = 1'b1;
        @(negedge gclk);
        for (int i = 0; i < 2; i++) chk($sformatf("L i%0d t5 after release", i), rv0_v[i], 0);
        tick();

        // Sustained conflict: round-robin alternates, priority mode starves port 0 for MAXW cycles.
        drive(1, 8'h10, 1, 4'h0, 8'h05, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge gclk);
            chk($sformatf("L i0 rr k%0d", k), {gnt0_v[0], gnt1_v[0]}, (k % 2 == 1) ? 2'b10 : 2'b01);
            chk($sformatf("L i1 prio k%0d", k), {gnt0_v[1], gnt1_v[1]}, (k == 5 || k == 10) ? 2'b10 : 2'b01);
            if (k == 5)
                for (int i = 0; i < 2; i++) chk($sformatf("L i%0d t3 cnt", i), cnt_a[i], 4);
            tick();
        end
        idle();
        tick();

        // Saturation of the conflict counter.
        grst_n = 1'b0;
        tick();
        grst_n = 1'b1;
        drive(1, 8'h10, 1, 4'h0, 8'h05, 32'h0);
        repeat (65534) tick();
        @(negedge gclk);
        for (int i = 0; i < 2; i++) chk($sformatf("L i%0d cnt FFFE", i), cnt_a[i], 16'hFFFE);
        tick();
        @(negedge gclk);
        for (int i = 0; i < 2; i++) chk($sformatf("L i%0d cnt FFFF", i), cnt_a[i], 16'hFFFF);
        repeat (5) tick();
        @(negedge gclk);
        for (int i = 0; i < 2; i++) chk($sformatf("L i%0d cnt hold", i), cnt_a[i], 16'hFFFF);
        tick();
        idle();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
